// File: rtl/bike_decap_loader.sv
// bike_decap_loader: stream front/back end for the BIKE decapsulation core.
// Collects c0, c1, h0 and h1 from a DW-bit valid/ready stream (least-significant
// word first), pulses core_start, waits for a rising edge on core_done, then
// streams the captured KEY_W-bit shared key out as DW-bit words.
// Optional build macro BIKE_LOADER_TIMEOUT_EN adds a WAIT watchdog that raises
// a sticky err and emits an all-zero key after TIMEOUT_CYC cycles.
module bike_decap_loader #(
    parameter int R           = 127,
    parameter int W           = 5,
    parameter int POS_W       = 8,
    parameter int DW          = 32,
    parameter int KEY_W       = 512,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_last,
    output logic [R-1:0]         core_c0,
    output logic [R-1:0]         core_c1,
    output logic [W*POS_W-1:0]   core_h0_pos_flat,
    output logic [W*POS_W-1:0]   core_h1_pos_flat,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [KEY_W-1:0]     core_key,
    output logic                 busy,
    output logic                 err
);

    localparam int HW      = W * POS_W;
    localparam int NC      = (R + DW - 1) / DW;
    localparam int NH      = (HW + DW - 1) / DW;
    localparam int NK      = KEY_W / DW;
    localparam int TOTAL   = 2 * NC + 2 * NH;
    localparam int CNT_MAX = (TOTAL > NK) ? TOTAL : NK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] LAST_KEY  = CNT_W'(NK - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_ready_q;
    logic                core_start_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic [DW-1:0]       out_data_q;
    logic                busy_q;
    logic                done_prev_q;
    logic [KEY_W-1:0]    key_q;      // key words not yet presented on out_data
    logic [R-1:0]        c0_q, c1_q, c0_d, c1_d;
    logic [HW-1:0]       h0_q, h1_q, h0_d, h1_d;

    logic load_fire;
    logic done_rise;

    assign load_fire = in_valid & in_ready_q;
    assign done_rise = core_done & ~done_prev_q;

`ifdef BIKE_LOADER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] timer_q;
    logic             err_q;
    assign err = err_q;
`else
    // Watchdog absent in this build; the parameter is kept so instantiations stay identical.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign err = 1'b0;
`endif

    // Per-bit next value of each field: a bit takes in_data when the counter addresses its word.
    // Bits of a field's last word above the field width simply have no destination.
    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_c
            assign c0_d[gi] = (cnt_q == CNT_W'(gi / DW))      ? in_data[gi % DW] : c0_q[gi];
            assign c1_d[gi] = (cnt_q == CNT_W'(NC + gi / DW)) ? in_data[gi % DW] : c1_q[gi];
        end
        for (gi = 0; gi < HW; gi++) begin : g_h
            assign h0_d[gi] = (cnt_q == CNT_W'(2 * NC + gi / DW))      ? in_data[gi % DW] : h0_q[gi];
            assign h1_d[gi] = (cnt_q == CNT_W'(2 * NC + NH + gi / DW)) ? in_data[gi % DW] : h1_q[gi];
        end
    endgenerate

    // Control FSM with registered outputs; also owns the field, key and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LOAD;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_prev_q  <= 1'b0;
            key_q        <= '0;
            c0_q         <= '0;
            c1_q         <= '0;
            h0_q         <= '0;
            h1_q         <= '0;
`ifdef BIKE_LOADER_TIMEOUT_EN
            timer_q      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_fire) begin
                        c0_q <= c0_d;
                        c1_q <= c1_d;
                        h0_q <= h0_d;
                        h1_q <= h1_d;
                        if (cnt_q == LAST_LOAD) begin
                            cnt_q        <= '0;
                            state_q      <= S_LAUNCH;
                            in_ready_q   <= 1'b0;
                            core_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    // Re-arm the edge detector so a done level left from a prior run is ignored.
                    core_start_q <= 1'b0;
                    done_prev_q  <= core_done;
                    state_q      <= S_WAIT;
`ifdef BIKE_LOADER_TIMEOUT_EN
                    timer_q      <= '0;
`endif
                end
                S_WAIT: begin
                    done_prev_q <= core_done;
                    if (done_rise) begin
                        out_data_q  <= core_key[DW-1:0];
                        key_q       <= core_key >> DW;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (NK == 1);
                        state_q     <= S_UNLOAD;
                    end
`ifdef BIKE_LOADER_TIMEOUT_EN
                    else if (timer_q == TMR_LAST) begin
                        err_q       <= 1'b1;
                        key_q       <= '0;
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (NK == 1);
                        state_q     <= S_UNLOAD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_KEY) begin
                            cnt_q       <= '0;
                            key_q       <= '0;
                            out_data_q  <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= S_LOAD;
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            out_data_q <= key_q[DW-1:0];
                            key_q      <= key_q >> DW;
                            out_last_q <= ((cnt_q + 1'b1) == LAST_KEY);
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign in_ready         = in_ready_q;
    assign core_start       = core_start_q;
    assign out_valid        = out_valid_q;
    assign out_last         = out_last_q;
    assign out_data         = out_data_q;
    assign busy             = busy_q;
    assign core_c0          = c0_q;
    assign core_c1          = c1_q;
    assign core_h0_pos_flat = h0_q;
    assign core_h1_pos_flat = h1_q;

endmodule

// File: tb/tb_bike_decap_loader.sv
// Directed bench for bike_decap_loader: load / launch / wait / unload, stalls,
// mid-load reset and (when BIKE_LOADER_TIMEOUT_EN is defined) the watchdog.
module tb_bike_decap_loader;

    localparam int R     = 127;
    localparam int W     = 5;
    localparam int POS_W = 8;
    localparam int DW    = 32;
    localparam int KEY_W = 512;
    localparam int NK    = 16;
`ifdef BIKE_LOADER_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65535;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DW-1:0]      in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic [R-1:0]       core_c0, core_c1;
    logic [W*POS_W-1:0] core_h0_pos_flat, core_h1_pos_flat;
    logic               core_start;
    logic               core_done = 1'b0;
    logic [KEY_W-1:0]   core_key = '0;
    logic               busy;
    logic               err;

    int n_checks = 0;
    int n_fail   = 0;

    bike_decap_loader #(
        .R(R), .W(W), .POS_W(POS_W), .DW(DW), .KEY_W(KEY_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_c0(core_c0), .core_c1(core_c1),
        .core_h0_pos_flat(core_h0_pos_flat), .core_h1_pos_flat(core_h1_pos_flat),
        .core_start(core_start), .core_done(core_done), .core_key(core_key),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           set;
        string        name;
        int           sel;
        logic [127:0] exp;
    } field_vec_t;

    logic [DW-1:0] words [2][12];
    field_vec_t    fields [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] field_val(input int sel);
        case (sel)
            0:       return {1'b0, core_c0};
            1:       return {1'b0, core_c1};
            2:       return {88'd0, core_h0_pos_flat};
            default: return {88'd0, core_h1_pos_flat};
        endcase
    endfunction

    task automatic check_fields(input int set);
        for (int i = 0; i < 8; i++)
            if (fields[i].set == set) check(fields[i].name, field_val(fields[i].sel), fields[i].exp);
    endtask

    task automatic load_words(input int n, input int set);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = words[set][i];
            check("load_in_ready", {127'd0, in_ready}, 1);
            check("load_no_start", {127'd0, core_start}, 0);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_launch();
        check("launch_start", {127'd0, core_start}, 1);
        check("launch_in_ready", {127'd0, in_ready}, 0);
        check("launch_busy", {127'd0, busy}, 1);
        tick();
        check("start_one_cycle", {127'd0, core_start}, 0);
    endtask

    // Drains NK key words with a random out_ready and a forced 3-cycle stall at word 5.
    task automatic unload(input bit zeros);
        int idx   = 0;
        int stall = 0;
        int cyc   = 0;
        logic [DW-1:0] exp;
        while (idx < NK && cyc < 400) begin
            if (idx == 5 && stall < 3) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 3) != 0);
            exp = zeros ? '0 : DW'(32'hF0 + idx);
            if (!out_ready && idx == 5) begin
                check("stall_data_hold", {96'd0, out_data}, {96'd0, exp});
                stall++;
            end
            if (out_valid && out_ready) begin
                check("unload_data", {96'd0, out_data}, {96'd0, exp});
                check("unload_last", {127'd0, out_last}, {127'd0, (idx == NK - 1)});
                idx++;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("unload_word_count", 128'(idx), 128'(NK));
        check("unload_done_valid", {127'd0, out_valid}, 0);
        check("unload_done_ready", {127'd0, in_ready}, 1);
        check("unload_done_busy", {127'd0, busy}, 0);
    endtask

    initial begin
        int seen;

        words[0] = '{32'h00001234, 32'h0, 32'h0, 32'h0, 32'h00005678, 32'h0, 32'h0, 32'h0,
                     32'h02030405, 32'h01, 32'h0708090A, 32'h06};
        words[1] = '{32'hAAAABBBB, 32'h11112222, 32'h33334444, 32'hFFFFFFFF,
                     32'h00000001, 32'h00000002, 32'h00000003, 32'h80000004,
                     32'hCAFEBABE, 32'hFFFFFF12, 32'h0BADF00D, 32'h00000034};
        fields[0] = '{0, "c0_a", 0, 128'h1234};
        fields[1] = '{0, "c1_a", 1, 128'h5678};
        fields[2] = '{0, "h0_a", 2, 128'h01_02030405};
        fields[3] = '{0, "h1_a", 3, 128'h06_0708090A};
        fields[4] = '{1, "c0_b", 0, 128'h7FFFFFFF_33334444_11112222_AAAABBBB};
        fields[5] = '{1, "c1_b", 1, 128'h00000004_00000003_00000002_00000001};
        fields[6] = '{1, "h0_b", 2, 128'h12_CAFEBABE};
        fields[7] = '{1, "h1_b", 3, 128'h34_0BADF00D};
        for (int k = 0; k < NK; k++) core_key[k*DW +: DW] = DW'(32'hF0 + k);

        // Reset state
        tick();
        tick();
        rst = 1'b1;
        check("rst_in_ready", {127'd0, in_ready}, 1);
        check("rst_busy", {127'd0, busy}, 0);
        check("rst_out_valid", {127'd0, out_valid}, 0);
        check("rst_core_start", {127'd0, core_start}, 0);
        check("rst_err", {127'd0, err}, 0);
        check("rst_out_data", {96'd0, out_data}, 0);
        check("rst_c0", {1'b0, core_c0}, 0);

        // Run 1: done already high before launch must not be captured
        core_done = 1'b1;
        load_words(12, 0);
        check_launch();
        check_fields(0);
        seen = 0;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        for (int i = 0; i < 50; i++) begin
            if (out_valid || in_ready) seen++;
            tick();
        end
        in_valid = 1'b0;
        check("held_done_ignored", 128'(seen), 0);
        check("wait_busy", {127'd0, busy}, 1);
        check("wait_input_ignored", {1'b0, core_c0}, 128'h1234);
        core_done = 1'b0;
        tick();
        check("no_valid_before_edge", {127'd0, out_valid}, 0);
        core_done = 1'b1;
        tick();
        check("edge_out_valid", {127'd0, out_valid}, 1);
        check("edge_first_word", {96'd0, out_data}, 128'hF0);
        unload(1'b0);
        check("c0_stable_after_run", {1'b0, core_c0}, 128'h1234);
        core_done = 1'b0;

        // Reset during a partial load
        load_words(6, 1);
        rst = 1'b0;
        #1;
        check("abort_c0_cleared", {1'b0, core_c0}, 0);
        check("abort_busy", {127'd0, busy}, 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (core_start) seen++;
            tick();
        end
        check("abort_no_start", 128'(seen), 0);
        rst = 1'b1;
        check("abort_in_ready", {127'd0, in_ready}, 1);
        load_words(12, 1);
        check_launch();
        check_fields(1);

`ifdef BIKE_LOADER_TIMEOUT_EN
        // Watchdog: done never rises; 100 WAIT cycles then zero key
        for (int i = 0; i < 99; i++) tick();
        check("tmo_err_before", {127'd0, err}, 0);
        check("tmo_valid_before", {127'd0, out_valid}, 0);
        tick();
        check("tmo_err_set", {127'd0, err}, 1);
        check("tmo_out_valid", {127'd0, out_valid}, 1);
        unload(1'b1);
        check("tmo_err_sticky", {127'd0, err}, 1);
`else
        // Without the watchdog WAIT persists indefinitely
        for (int i = 0; i < 150; i++) tick();
        check("nowd_still_waiting", {127'd0, out_valid}, 0);
        check("nowd_busy", {127'd0, busy}, 1);
        check("nowd_err", {127'd0, err}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bike_decap_loader.md
Name: bike_decap_loader

Overview:
- Bus-side front/back end for the BIKE decapsulation core; sits directly upstream and downstream of it.
- Deserialises ciphertext (c0, c1) and the secret-key support positions (h0, h1) from a DW-bit valid/ready stream into wide registers, then pulses the core start.
- Waits for the core's completion, captures the 512-bit shared key and streams it out as DW-bit words.

Parameters:
- R, 127, ring size; width of c0 and c1.
- W, 5, number of support positions per h block.
- POS_W, 8, bits per support position.
- DW, 32, stream word width.
- KEY_W, 512, shared-key width; must be a multiple of DW.
- TIMEOUT_CYC, 65535, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts an input word.
- in_data  in  DW  input word.
- out_valid  out  1  key word valid.
- out_ready  in  1  downstream accepts a key word.
- out_data  out  DW  key word.
- out_last  out  1  high with the final key word.
- core_c0, core_c1  out  R  registered ciphertext halves.
- core_h0_pos_flat, core_h1_pos_flat  out  W*POS_W  registered support positions.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core completion; may stay high after completion.
- core_key  in  KEY_W  shared key from the core.
- busy  out  1  high in every state except LOAD.
- err  out  1  sticky watchdog error; constant 0 when the feature is off.

Behaviour:
- Reset (rst=0), taking effect immediately:
  - FSM goes to LOAD; word counter = 0.
  - All core_* data registers, the key register, out_data, core_start, out_valid, out_last, busy and err are 0.
  - in_ready = 1 in the first cycle after reset releases.
- Word counts: NC = ceil(R/DW) (4 at defaults); NH = ceil(W*POS_W/DW) (2); NK = KEY_W/DW (16). Load total = 2*NC + 2*NH (12).
- Load order, least-significant word first:
  - c0 (NC words), then c1 (NC), then h0 (NH), then h1 (NH).
  - Bits of the last word of each field above the field width are discarded.
- FSM states:
  - LOAD: in_ready = 1. Each in_valid&in_ready cycle writes in_data into the addressed slice and increments the counter. On acceptance of the final word go to LAUNCH; the counter clears.
  - LAUNCH: in_ready = 0; core_start = 1 for exactly this one cycle; the core_done edge detector is re-armed with the current core_done level. Next state is WAIT.
  - WAIT: act only on a rising edge of core_done (core_done = 1 while the previous sample was 0). A done level held over from a prior run is ignored. On the edge, register core_key and go to UNLOAD. Latency from that edge to out_valid = 1 is one cycle.
  - UNLOAD: out_valid = 1; out_data = key word[idx] with idx 0 = bits DW-1:0. On out_valid&out_ready, increment idx. out_last = 1 when idx = NK-1. Handshake of the last word returns to LOAD and clears the key register.
- Output stability: out_data and out_last hold stable while out_valid & !out_ready.
- in_valid outside LOAD is ignored and no data is lost to the source, because in_ready = 0.
- core_c*/core_h* registers update only in LOAD and stay stable from LAUNCH through UNLOAD.
- Reset mid-operation: everything aborts to the reset values. A partial load is discarded and no start pulse is issued.
- A new load may begin in the cycle after the last key-word handshake.

Optional Feature:
- Macro: BIKE_LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYC without a core_done rising edge, err is set (sticky until reset), the key register is zeroed, and the FSM goes to UNLOAD, so NK all-zero words are emitted.
  - The counter clears on entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; err is tied to 0.

Test Plan:
- Reset, then check outputs: in_ready=1, busy=0, out_valid=0, core_start=0, err=0.
- Load 12 words 0x00001234,0,0,0,0x00005678,0,0,0,0x02030405,0x01,0x0708090A,0x06 with in_valid held high. Required response:
  - core_c0 = 127'h1234, core_c1 = 127'h5678.
  - core_h0_pos_flat = 40'h01_02_03_04_05, core_h1_pos_flat = 40'h06_07_08_09_0A.
  - core_start high exactly one cycle, in the cycle after the 12th handshake.
- Hold core_done = 1 before LAUNCH, then pulse it low→high after 50 cycles with core_key = {16 words 0x000000F0..0x000000FF}. Required response:
  - No capture on the held-high level.
  - After the edge, out words arrive 0xF0 first through 0xFF last, with out_last only on 0xFF.
- During UNLOAD, toggle out_ready randomly (stall 3 cycles at word 5). Required response: out_data stays at word 5 while stalled; 16 words total, none duplicated or dropped.
- Assert rst=0 after 6 of 12 words, then release and load a full 12 words. Required response: no core_start during the abort; the second load's values appear intact on the core_* outputs.
- With BIKE_LOADER_TIMEOUT_EN and TIMEOUT_CYC=100, never raise core_done. Required response: err=1 after 100 WAIT cycles, then 16 zero words with out_last on the 16th.
